lcd_display: RTL and testbench

//  Self-running HD44780-style LCD write sequencer. After reset it issues a fixed
//  4-command init sequence, then writes the string "HELLO WORLD" (11 chars) over
//  an 8-bit parallel bus with RS/RW/EN strobes, then idles. Sits between the

---
 rtl/lcd_display.sv | 110 +++++++++++
 tb/tb_lcd_display.sv | 133 +++++++++++++
 2 files changed

// File: rtl/lcd_display.sv
// HD44780-style write sequencer: after reset it walks a 15-entry item ROM
// (4 init commands, then "HELLO WORLD") with setup/pulse/hold framing per item.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_SEND | walking the item ROM; phase counter frames each transfer
//   ST_DONE | sequence complete; bus parked on the last char, en low
module lcd_display #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] data,
  output logic       rs,
  output logic       rw,
  output logic       en
);

  localparam int XFER_CYC = SETUP_CYC + PULSE_CYC + HOLD_CYC;
  localparam int CNT_W    = (XFER_CYC > 2) ? $clog2(XFER_CYC) : 1;

  localparam logic [CNT_W-1:0] P_EN_ON  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] P_EN_OFF = CNT_W'(SETUP_CYC + PULSE_CYC);
  localparam logic [CNT_W-1:0] P_LAST   = CNT_W'(XFER_CYC - 1);

  localparam logic [3:0] LAST_IDX  = 4'd14;
  localparam logic [3:0] FIRST_CHR = 4'd4;

  typedef enum logic {
    ST_SEND,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [CNT_W-1:0] p_q;
  logic [7:0]       data_q;
  logic             rs_q;
  logic             en_q;

  function automatic logic [7:0] item_rom(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h38;
      4'd1:    b = 8'h0C;
      4'd2:    b = 8'h06;
      4'd3:    b = 8'h01;
      4'd4:    b = 8'h48;
      4'd5:    b = 8'h45;
      4'd6:    b = 8'h4C;
      4'd7:    b = 8'h4C;
      4'd8:    b = 8'h4F;
      4'd9:    b = 8'h20;
      4'd10:   b = 8'h57;
      4'd11:   b = 8'h4F;
      4'd12:   b = 8'h52;
      4'd13:   b = 8'h4C;
      4'd14:   b = 8'h44;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Outputs are registered from the current (idx, p), so the pins trail the
  // counter by one edge: the first edge out of reset presents item 0 at p=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SEND;
      idx_q   <= '0;
      p_q     <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_SEND: begin
          data_q <= item_rom(idx_q);
          rs_q   <= (idx_q >= FIRST_CHR);
          en_q   <= (p_q >= P_EN_ON) && (p_q < P_EN_OFF);
          if (p_q == P_LAST) begin
            p_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else begin
            p_q <= p_q + 1'b1;
          end
        end
        ST_DONE: begin
          data_q <= 8'h44;
          rs_q   <= 1'b1;
          en_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_SEND;
        end
      endcase
    end
  end

  assign data = data_q;
  assign rs   = rs_q;
  assign en   = en_q;
  assign rw   = 1'b0;

endmodule

// File: tb/tb_lcd_display.sv
// Bench for lcd_display: default-timing and 1/1/1-timing instances driven by a
// shared reset pattern, checked against a cycle-number model of the pin protocol.
module tb_lcd_display;

  logic       clk;
  logic       reset;
  logic [7:0] data_a, data_b;
  logic       rs_a, rs_b, rw_a, rw_b, en_a, en_b;

  int n_chk = 0;
  int n_bad = 0;

  lcd_display #(.SETUP_CYC(2), .PULSE_CYC(4), .HOLD_CYC(2)) dut_a (
    .clk(clk), .reset(reset), .data(data_a), .rs(rs_a), .rw(rw_a), .en(en_a)
  );

  lcd_display #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut_b (
    .clk(clk), .reset(reset), .data(data_b), .rs(rs_b), .rw(rw_b), .en(en_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  string      msg = "HELLO WORLD";

  int         cyc;        // cycle number since reset release (0 = reset edge)
  logic [8:0] qa[$];      // {rs,data} captured at each en rising edge
  logic [8:0] qb[$];
  logic       en_a_prev, en_b_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] item_byte(input int k);
    if (k < 4) return cmds[k];
    return msg[k-4];
  endfunction

  // Pin state expected after the edge numbered c, for the given framing.
  task automatic model(input int c, input int s, input int pw, input int h,
                       output logic [7:0] d, output logic r, output logic e);
    int t, k, p;
    t = s + pw + h;
    if (c == 0) begin
      d = 8'h00; r = 1'b0; e = 1'b0;
    end else if (c <= 15 * t) begin
      k = (c - 1) / t;
      p = (c - 1) % t;
      d = item_byte(k);
      r = (k >= 4);
      e = (p >= s) && (p < s + pw);
    end else begin
      d = 8'h44; r = 1'b1; e = 1'b0;
    end
  endtask

  task automatic check_stream(input string tag, input logic [8:0] q[$]);
    chk({tag, "_strobes"}, q.size(), 15);
    for (int i = 0; i < 15 && i < q.size(); i++)
      chk($sformatf("%s_item%0d", tag, i), q[i], {(i >= 4) ? 1'b1 : 1'b0, item_byte(i)});
  endtask

  task automatic step();
    logic [7:0] d;
    logic       r, e;
    logic       rst_at_edge;
    rst_at_edge = reset;
    @(posedge clk);
    #1;
    if (rst_at_edge) begin
      cyc = 0;
      qa.delete();
      qb.delete();
      en_a_prev = 1'b0;
      en_b_prev = 1'b0;
    end else if (cyc < 10000) begin
      cyc++;
    end

    model(cyc, 2, 4, 2, d, r, e);
    chk("a_data", data_a, d);
    chk("a_rs", rs_a, r);
    chk("a_en", en_a, e);
    chk("a_rw", rw_a, 0);
    model(cyc, 1, 1, 1, d, r, e);
    chk("b_data", data_b, d);
    chk("b_rs", rs_b, r);
    chk("b_en", en_b, e);
    chk("b_rw", rw_b, 0);

    if (en_a && !en_a_prev) qa.push_back({rs_a, data_a});
    if (en_b && !en_b_prev) qb.push_back({rs_b, data_b});
    en_a_prev = en_a;
    en_b_prev = en_b;
    if (cyc == 121) check_stream("a", qa);
    if (cyc == 46)  check_stream("b", qb);
  endtask

  // n edges; reset high during [r0, r0+l0) and [r1, r1+l1) of the run
  task automatic run(input int n, input int r0, input int l0, input int r1, input int l1);
    for (int i = 0; i < n; i++) begin
      reset = ((i >= r0) && (i < r0 + l0)) || ((i >= r1) && (i < r1 + l1));
      step();
    end
  endtask

  initial begin
    int r1, l0, l1;
    reset     = 1'b1;
    cyc       = 0;
    en_a_prev = 1'b0;
    en_b_prev = 1'b0;

    run(140, 0, 1, -10, 0);
    run(160, 0, 1, 50, 1);
    for (int it = 0; it < 8; it++) begin
      l0 = $urandom_range(1, 3);
      r1 = $urandom_range(5, 125);
      l1 = $urandom_range(1, 3);
      run(r1 + l1 + 135, 0, l0, r1, l1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
